// File: rtl/rx_pkt_pkg.sv
// rx_pkt_pkg: shared types and helpers for the RX store-and-forward packet FIFO
package rx_pkt_pkg;
  localparam int DATA_W = 64;
  localparam int KEEP_W = 8;
  typedef enum logic [1:0] {IDLE, STORE, DROP} wr_state_e;
  typedef struct packed {
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tlast;
  } beat_t;
  function automatic logic keep_is_contiguous(input logic [KEEP_W-1:0] k);
    return (k != '0) && ((k & (k + KEEP_W'(1))) == '0);
  endfunction
endpackage

// File: rtl/rx_pkt_ram.sv
// rx_pkt_ram: one write port, one asynchronous read port beat storage
module rx_pkt_ram #(
  parameter int DEPTH = 512,
  parameter int W     = 73
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/axis_rx_pkt_fifo.sv
// axis_rx_pkt_fifo: store-and-forward AXI-Stream RX FIFO that drops bad, oversize and overflowing frames
module axis_rx_pkt_fifo #(
  parameter int DATA_W    = 64,
  parameter int KEEP_W    = 8,
  parameter int DEPTH     = 512,
  parameter int MAX_BEATS = 256
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic [KEEP_W-1:0] s_axis_tkeep,
  input  logic              s_axis_tlast,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic [KEEP_W-1:0] m_axis_tkeep,
  output logic              m_axis_tlast,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [31:0]       frame_cnt,
  output logic [31:0]       drop_cnt
);
  import rx_pkt_pkg::*;
  localparam int PW = $clog2(DEPTH);
  localparam int BW = $clog2(MAX_BEATS);
  localparam logic [PW:0] ONE  = (PW+1)'(1);
  localparam logic [PW:0] WRAP = ONE << PW;
  wr_state_e     state, state_n;
  logic [PW:0]   wr_ptr, wr_commit, rd_ptr;
  logic [BW-1:0] beat_cnt;
  logic          acc, full, bad_keep, too_long, err, we, commit, drop, empty, load;
  beat_t         wr_beat, rd_beat;
  assign wr_beat = '{tdata: s_axis_tdata, tkeep: s_axis_tkeep, tlast: s_axis_tlast};
  // Fullness sees rd_ptr from the previous cycle, so a same-cycle read never frees a slot early
  always_comb begin
    acc      = s_axis_tvalid & s_axis_tready;
    full     = (wr_ptr + ONE) == (rd_ptr ^ WRAP);
    bad_keep = s_axis_tlast ? !keep_is_contiguous(s_axis_tkeep) : s_axis_tkeep != '1;
    too_long = !s_axis_tlast && beat_cnt == BW'(MAX_BEATS - 1);
    err      = full | bad_keep | too_long;
    we       = acc && state != DROP && !err;
    commit   = we && s_axis_tlast;
    drop     = acc && s_axis_tlast && !we;
    state_n  = !acc ? state : s_axis_tlast ? IDLE : (state == DROP || err) ? DROP : STORE;
    empty    = rd_ptr == wr_commit;
    load     = (!m_axis_tvalid || m_axis_tready) && !empty;
  end
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      s_axis_tready <= 1'b0;
      wr_ptr        <= '0;
      wr_commit     <= '0;
      beat_cnt      <= '0;
      frame_cnt     <= '0;
      drop_cnt      <= '0;
    end else begin
      s_axis_tready <= 1'b1;
      if (acc) beat_cnt <= s_axis_tlast ? '0 : beat_cnt + BW'(1);
      if (we) wr_ptr <= wr_ptr + ONE;
      if (drop) begin
        wr_ptr   <= wr_commit;
        drop_cnt <= drop_cnt + 32'd1;
      end
      if (commit) begin
        wr_commit <= wr_ptr + ONE;
        frame_cnt <= frame_cnt + 32'd1;
      end
    end
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      rd_ptr        <= '0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tvalid <= 1'b0;
    end else if (load) begin
      rd_ptr        <= rd_ptr + ONE;
      m_axis_tdata  <= rd_beat.tdata;
      m_axis_tkeep  <= rd_beat.tkeep;
      m_axis_tlast  <= rd_beat.tlast;
      m_axis_tvalid <= 1'b1;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  rx_pkt_ram #(.DEPTH(DEPTH), .W($bits(beat_t))) u_ram (
    .clk  (aclk),
    .we   (we),
    .waddr(wr_ptr[PW-1:0]),
    .wdata(wr_beat),
    .raddr(rd_ptr[PW-1:0]),
    .rdata(rd_beat)
  );
endmodule

// File: tb/tb_axis_rx_pkt_fifo.sv
// tb_axis_rx_pkt_fifo: directed frames with a scoreboard queue checked by an output monitor
module tb_axis_rx_pkt_fifo;
  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [63:0] s_axis_tdata;
  logic [7:0]  s_axis_tkeep;
  logic        s_axis_tlast;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic        m_axis_tlast;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [31:0] frame_cnt;
  logic [31:0] drop_cnt;
  typedef struct packed {logic [63:0] d; logic [7:0] k; logic l;} exp_t;
  exp_t        q[$];
  int          total = 0;
  int          bad = 0;
  int          exp_frames = 0;
  int          exp_drops = 0;
  logic        stall = 1'b0;
  logic [72:0] prev_beat;
  axis_rx_pkt_fifo #(.DATA_W(64), .KEEP_W(8), .DEPTH(16), .MAX_BEATS(8)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
  );
  always #5 aclk = ~aclk;
  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  always @(negedge aclk) begin : monitor
    exp_t e;
    if (!aresetn) stall = 1'b0;
    else begin
      if (stall) begin
        chk("hold_valid", 80'(m_axis_tvalid), 80'(1));
        chk("hold_beat", 80'({m_axis_tdata, m_axis_tkeep, m_axis_tlast}), 80'(prev_beat));
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL out_unexpected: got beat %h want none", m_axis_tdata);
        end else begin
          e = q.pop_front();
          chk("out_beat", 80'({m_axis_tdata, m_axis_tkeep, m_axis_tlast}), 80'(e));
        end
      end
      stall = m_axis_tvalid && !m_axis_tready;
      prev_beat = {m_axis_tdata, m_axis_tkeep, m_axis_tlast};
    end
  end
  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
    s_axis_tdata = d;
    s_axis_tkeep = k;
    s_axis_tlast = l;
    s_axis_tvalid = 1'b1;
    chk("s_tready", 80'(s_axis_tready), 80'(1));
    @(posedge aclk);
    #1;
  endtask
  task automatic send_frame(input logic [63:0] base, input int n, input logic [7:0] lk,
                            input int bad_at, input logic [7:0] bk, input logic pass);
    for (int i = 0; i < n; i++) begin
      logic [7:0] k;
      k = (i == n - 1) ? lk : 8'hFF;
      if (i == bad_at) k = bk;
      if (pass) q.push_back('{base + 64'(i), k, i == n - 1});
      send_beat(base + 64'(i), k, i == n - 1);
    end
    s_axis_tvalid = 1'b0;
  endtask
  task automatic send_fa();
    logic [63:0] fa [4];
    fa = '{64'hABCDEF10ABCDEF10, 64'h4353456346346343, 64'h4378654876545566, 64'h123456789ABCDEF0};
    for (int i = 0; i < 4; i++) begin
      q.push_back('{fa[i], 8'hFF, i == 3});
      send_beat(fa[i], 8'hFF, i == 3);
    end
    s_axis_tvalid = 1'b0;
  endtask
  task automatic drain(input string name);
    int n;
    n = 0;
    while ((q.size() != 0 || m_axis_tvalid) && n < 400) begin
      @(posedge aclk);
      #1;
      n++;
    end
    chk({name, "_queue"}, 80'(q.size()), 80'(0));
    chk({name, "_idle"}, 80'(m_axis_tvalid), 80'(0));
  endtask
  task automatic chk_cnt(input string name);
    chk({name, "_frames"}, 80'(frame_cnt), 80'(exp_frames));
    chk({name, "_drops"}, 80'(drop_cnt), 80'(exp_drops));
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end
  initial begin
    s_axis_tdata = '0;
    s_axis_tkeep = '0;
    s_axis_tlast = 1'b0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_s_tready", 80'(s_axis_tready), 80'(0));
    chk("rst_m_tvalid", 80'(m_axis_tvalid), 80'(0));
    chk_cnt("rst");
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    chk("s_tready_up", 80'(s_axis_tready), 80'(1));
    send_fa();
    chk("lat_edge_k", 80'(m_axis_tvalid), 80'(0));
    @(posedge aclk);
    #1;
    chk("lat_edge_k1", 80'(m_axis_tvalid), 80'(1));
    drain("t1");
    exp_frames = 1;
    chk_cnt("t1");
    send_frame(64'h2000_0000_0000_0000, 2, 8'h0F, -1, 8'h00, 1'b1);
    exp_frames++;
    send_frame(64'h2100_0000_0000_0000, 2, 8'h0B, -1, 8'h00, 1'b0);
    exp_drops++;
    drain("t2");
    chk_cnt("t2");
    m_axis_tready = 1'b0;
    send_frame(64'h3000_0000_0000_0000, 3, 8'hFF, -1, 8'h00, 1'b1);
    send_frame(64'h3100_0000_0000_0000, 3, 8'h3F, -1, 8'h00, 1'b1);
    exp_frames += 2;
    repeat (4) @(posedge aclk);
    #1;
    chk("t3_stall_valid", 80'(m_axis_tvalid), 80'(1));
    chk_cnt("t3");
    m_axis_tready = 1'b1;
    drain("t3");
    m_axis_tready = 1'b0;
    send_frame(64'h4000_0000_0000_0000, 7, 8'hFF, -1, 8'h00, 1'b1);
    send_frame(64'h4100_0000_0000_0000, 7, 8'h07, -1, 8'h00, 1'b1);
    send_frame(64'h4200_0000_0000_0000, 7, 8'hFF, -1, 8'h00, 1'b0);
    exp_frames += 2;
    exp_drops++;
    chk_cnt("t4_ovf");
    repeat (3) @(posedge aclk);
    #1;
    m_axis_tready = 1'b1;
    drain("t4_ovf");
    send_fa();
    exp_frames++;
    drain("t4_after");
    chk_cnt("t4_after");
    send_frame(64'h5000_0000_0000_0000, 9, 8'hFF, -1, 8'h00, 1'b0);
    exp_drops++;
    send_frame(64'h5100_0000_0000_0000, 8, 8'hFF, -1, 8'h00, 1'b1);
    exp_frames++;
    send_frame(64'h5200_0000_0000_0000, 3, 8'hFF, 0, 8'h7F, 1'b0);
    exp_drops++;
    send_frame(64'h5300_0000_0000_0000, 2, 8'h01, -1, 8'h00, 1'b1);
    exp_frames++;
    drain("t5");
    chk_cnt("t5");
    send_beat(64'h6000_0000_0000_0000, 8'hFF, 1'b0);
    send_beat(64'h6000_0000_0000_0001, 8'hFF, 1'b0);
    aresetn = 1'b0;
    s_axis_tvalid = 1'b0;
    #1;
    exp_frames = 0;
    exp_drops = 0;
    chk("t6_rst_m_tvalid", 80'(m_axis_tvalid), 80'(0));
    chk("t6_rst_s_tready", 80'(s_axis_tready), 80'(0));
    chk_cnt("t6_rst");
    repeat (2) @(posedge aclk);
    #1;
    chk("t6_hold_s_tready", 80'(s_axis_tready), 80'(0));
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    send_fa();
    exp_frames = 1;
    drain("t6");
    chk_cnt("t6");
    chk("sb_empty", 80'(q.size()), 80'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
